// File: rtl/microwave_pkg.sv
// Shared state encoding and time constants for the microwave cook-cycle controller.
// Pure declarations: no latency, no flow control.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    COOKING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } cook_state_t;

  localparam int MAX_TIME_S  = 5999;
  localparam int QUICK_ADD_S = 30;

endpackage

// File: rtl/microwave_cook_sequencer_if.sv
// Front-end commands in, power/indicator outputs back; master = keypad/door side, slave = sequencer.
// Level and pulse signals only: no handshake, so the sequencer never stalls its front end.
interface microwave_cook_sequencer_if #(
  parameter int TIME_W = 13
);

  logic              tick_1hz;
  logic              door_open;
  logic              load;
  logic [TIME_W-1:0] load_value;
  logic              start;
  logic              stop_clear;

  logic [TIME_W-1:0] remaining;
  logic              magnetron_on;
  logic              lamp_on;
  logic              beep;
  logic              done;
  logic [2:0]        state_o;

  modport master (
    output tick_1hz, door_open, load, load_value, start, stop_clear,
    input  remaining, magnetron_on, lamp_on, beep, done, state_o
  );

  modport slave (
    input  tick_1hz, door_open, load, load_value, start, stop_clear,
    output remaining, magnetron_on, lamp_on, beep, done, state_o
  );

endinterface

// File: rtl/cook_time_down_counter.sv
// Cook-time register: clear > clamped load > saturating decrement > hold; one-cycle update.
// No backpressure; every command is applied on the next clock edge.
module cook_time_down_counter #(
  parameter int TIME_W   = 13,
  parameter int MAX_TIME = 5999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic [TIME_W:0]   ld_val,
  input  logic              dec,
  output logic [TIME_W-1:0] remaining,
  output logic              at_one,
  output logic              is_zero
);

  localparam logic [TIME_W:0]   MAX_W = (TIME_W+1)'(MAX_TIME);
  localparam logic [TIME_W-1:0] ONE   = {{(TIME_W-1){1'b0}}, 1'b1};

  logic [TIME_W-1:0] remaining_d, remaining_q;
  logic [TIME_W-1:0] ld_clamped;

  // Load value is one bit wider so a quick-add sum can exceed MAX_TIME before clamping.
  always_comb begin
    ld_clamped  = (ld_val > MAX_W) ? MAX_W[TIME_W-1:0] : ld_val[TIME_W-1:0];
    remaining_d = remaining_q;
    if (clr) begin
      remaining_d = '0;
    end else if (ld) begin
      remaining_d = ld_clamped;
    end else if (dec && (remaining_q != '0)) begin
      remaining_d = remaining_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign remaining = remaining_q;
  assign at_one    = (remaining_q == ONE);
  assign is_zero   = (remaining_q == '0);

endmodule

// File: rtl/microwave_cook_sequencer.sv
// Cook-cycle FSM with door-interlocked magnetron, lamp and end-of-cycle beeper; MICROWAVE_QUICK_START_EN adds 30 s quick start.
// State/remaining/beep/done update one cycle after the event; magnetron_on and lamp_on react combinationally to the door.
module microwave_cook_sequencer
  import microwave_pkg::*;
#(
  parameter int TIME_W     = 13,
  parameter int MAX_TIME   = MAX_TIME_S,
  parameter int BEEP_TICKS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  microwave_cook_sequencer_if.slave    cif
);

  localparam int BC_W = $clog2(BEEP_TICKS + 1);
  localparam logic [BC_W-1:0] BEEP_LAST = BC_W'(BEEP_TICKS - 1);
  localparam logic [BC_W-1:0] BC_ONE    = {{(BC_W-1){1'b0}}, 1'b1};

  cook_state_t       state_d, state_q;
  logic [BC_W-1:0]   beep_cnt_d, beep_cnt_q;
  logic              beep_d, beep_q;
  logic              done_d, done_q;

  logic              cnt_clr;
  logic              cnt_ld;
  logic [TIME_W:0]   cnt_ld_val;
  logic              cnt_dec;
  logic [TIME_W-1:0] remaining_w;
  logic              at_one;
  logic              is_zero;
  logic              start_ok;
  logic              load_nz;

`ifdef MICROWAVE_QUICK_START_EN
  localparam logic [TIME_W:0] QUICK_W = (TIME_W+1)'(QUICK_ADD_S);
  logic [TIME_W:0] quick_sum;
  assign quick_sum = {1'b0, remaining_w} + QUICK_W;
`endif

  cook_time_down_counter #(
    .TIME_W   (TIME_W),
    .MAX_TIME (MAX_TIME)
  ) u_time (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .ld        (cnt_ld),
    .ld_val    (cnt_ld_val),
    .dec       (cnt_dec),
    .remaining (remaining_w),
    .at_one    (at_one),
    .is_zero   (is_zero)
  );

  // Clamping only shrinks values above MAX_TIME, so a nonzero raw load stays nonzero.
  assign load_nz  = |cif.load_value;
  assign start_ok = cif.start && !cif.door_open && !is_zero;

  always_comb begin
    state_d    = state_q;
    beep_cnt_d = beep_cnt_q;
    cnt_clr    = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = {1'b0, cif.load_value};
    cnt_dec    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cif.stop_clear) begin
          cnt_clr = 1'b1;
`ifdef MICROWAVE_QUICK_START_EN
        end else if (cif.start && !cif.door_open) begin
          cnt_ld     = 1'b1;
          cnt_ld_val = QUICK_W;
          state_d    = COOKING;
`endif
        end else if (cif.load) begin
          cnt_ld  = 1'b1;
          state_d = load_nz ? ARMED : IDLE;
        end
      end

      ARMED: begin
        if (cif.stop_clear) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (start_ok) begin
          state_d = COOKING;
        end else if (cif.load) begin
          cnt_ld  = 1'b1;
          state_d = load_nz ? ARMED : IDLE;
        end
      end

      COOKING: begin
        // An open door outranks the tick, so the second during which it opened is not charged.
        if (cif.door_open || cif.stop_clear) begin
          state_d = PAUSED;
`ifdef MICROWAVE_QUICK_START_EN
        end else if (cif.start) begin
          cnt_ld     = 1'b1;
          cnt_ld_val = quick_sum;
`endif
        end else if (cif.tick_1hz) begin
          cnt_dec = 1'b1;
          if (at_one) begin
            state_d    = DONE;
            beep_cnt_d = '0;
          end
        end
      end

      PAUSED: begin
        if (cif.stop_clear) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (start_ok) begin
          state_d = COOKING;
        end
      end

      DONE: begin
        if (cif.door_open || cif.stop_clear) begin
          state_d    = IDLE;
          beep_cnt_d = '0;
        end else if (cif.tick_1hz) begin
          if (beep_cnt_q == BEEP_LAST) begin
            state_d    = IDLE;
            beep_cnt_d = '0;
          end else begin
            beep_cnt_d = beep_cnt_q + BC_ONE;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        beep_cnt_d = '0;
        cnt_clr    = 1'b1;
      end
    endcase

    beep_d = (state_d == DONE);
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
      done_q     <= done_d;
    end
  end

  assign cif.remaining    = remaining_w;
  assign cif.magnetron_on = (state_q == COOKING) && !cif.door_open;
  assign cif.lamp_on      = cif.door_open || (state_q == COOKING);
  assign cif.beep         = beep_q;
  assign cif.done         = done_q;
  assign cif.state_o      = state_q;

endmodule

// File: tb/tb_microwave_cook_sequencer.sv
// Directed-vector bench for microwave_cook_sequencer; expectations are hand-computed per vector.
module tb_microwave_cook_sequencer;
  import microwave_pkg::*;

  localparam int TW = 13;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  microwave_cook_sequencer_if #(.TIME_W(TW)) cif ();

  microwave_cook_sequencer #(
    .TIME_W     (TW),
    .MAX_TIME   (5999),
    .BEEP_TICKS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cif (cif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge, then drop all pulse inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cif.tick_1hz   = 1'b0;
    cif.load       = 1'b0;
    cif.start      = 1'b0;
    cif.stop_clear = 1'b0;
  endtask

  task automatic do_load(input logic [TW-1:0] v);
    cif.load       = 1'b1;
    cif.load_value = v;
    step();
  endtask

  initial begin
    rst            = 1'b1;
    cif.tick_1hz   = 1'b0;
    cif.door_open  = 1'b0;
    cif.load       = 1'b0;
    cif.load_value = '0;
    cif.start      = 1'b0;
    cif.stop_clear = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst_state", 32'(cif.state_o), 32'(IDLE));
    chk("rst_rem",   32'(cif.remaining), 32'd0);
    chk("rst_beep",  32'(cif.beep), 32'd0);
    chk("rst_done",  32'(cif.done), 32'd0);
    chk("rst_mag",   32'(cif.magnetron_on), 32'd0);
    chk("rst_lamp",  32'(cif.lamp_on), 32'd0);

    // Basic cycle
    do_load(13'd3);
    chk("b_armed", 32'(cif.state_o), 32'(ARMED));
    chk("b_rem3",  32'(cif.remaining), 32'd3);
    cif.start = 1'b1; step();
    chk("b_cook",  32'(cif.state_o), 32'(COOKING));
    chk("b_mag",   32'(cif.magnetron_on), 32'd1);
    chk("b_lamp",  32'(cif.lamp_on), 32'd1);
    cif.tick_1hz = 1'b1; step();
    chk("b_rem2",  32'(cif.remaining), 32'd2);
    step();
    chk("b_hold2", 32'(cif.remaining), 32'd2);
    chk("b_mag2",  32'(cif.magnetron_on), 32'd1);
    cif.tick_1hz = 1'b1; step();
    chk("b_rem1",  32'(cif.remaining), 32'd1);
    cif.tick_1hz = 1'b1; step();
    chk("b_rem0",  32'(cif.remaining), 32'd0);
    chk("b_done_st", 32'(cif.state_o), 32'(DONE));
    chk("b_done1", 32'(cif.done), 32'd1);
    chk("b_beep1", 32'(cif.beep), 32'd1);
    chk("b_magoff", 32'(cif.magnetron_on), 32'd0);
    step();
    chk("b_done0", 32'(cif.done), 32'd0);
    chk("b_beep_h", 32'(cif.beep), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cif.tick_1hz = 1'b1; step();
      chk("b_beep_tick", 32'(cif.state_o), 32'(DONE));
    end
    cif.tick_1hz = 1'b1; step();
    chk("b_end_st",   32'(cif.state_o), 32'(IDLE));
    chk("b_end_beep", 32'(cif.beep), 32'd0);

    // Door interlock
    do_load(13'd10);
    cif.start = 1'b1; step();
    chk("d_cook", 32'(cif.state_o), 32'(COOKING));
    cif.door_open = 1'b1;
    cif.tick_1hz  = 1'b1;
    #1;
    chk("d_mag_cut", 32'(cif.magnetron_on), 32'd0);
    chk("d_lamp",    32'(cif.lamp_on), 32'd1);
    step();
    chk("d_paused", 32'(cif.state_o), 32'(PAUSED));
    chk("d_rem10",  32'(cif.remaining), 32'd10);
    cif.door_open = 1'b0;
    cif.start     = 1'b1; step();
    chk("d_resume", 32'(cif.state_o), 32'(COOKING));

    // Stop/clear sequence
    for (int i = 0; i < 5; i++) begin
      cif.tick_1hz = 1'b1; step();
    end
    chk("s_rem5", 32'(cif.remaining), 32'd5);
    cif.stop_clear = 1'b1; step();
    chk("s_paused", 32'(cif.state_o), 32'(PAUSED));
    chk("s_hold5",  32'(cif.remaining), 32'd5);
    do_load(13'd20);
    chk("s_ld_ign",    32'(cif.remaining), 32'd5);
    chk("s_ld_ign_st", 32'(cif.state_o), 32'(PAUSED));
    cif.start = 1'b1; cif.stop_clear = 1'b1; step();
    chk("s_sc_wins", 32'(cif.state_o), 32'(IDLE));
    chk("s_clr",     32'(cif.remaining), 32'd0);

    // Clamp and zero load
    do_load(13'd7000);
    chk("c_clamp", 32'(cif.remaining), 32'd5999);
    chk("c_armed", 32'(cif.state_o), 32'(ARMED));
    cif.door_open = 1'b1;
    cif.start     = 1'b1; step();
    chk("c_door_blk", 32'(cif.state_o), 32'(ARMED));
    chk("c_lamp",     32'(cif.lamp_on), 32'd1);
    chk("c_mag",      32'(cif.magnetron_on), 32'd0);
    cif.door_open = 1'b0;
    do_load(13'd0);
    chk("c_zero_st",  32'(cif.state_o), 32'(IDLE));
    chk("c_zero_rem", 32'(cif.remaining), 32'd0);
    do_load(13'd4);
    cif.stop_clear = 1'b1; step();
    chk("c_arm_clr_st",  32'(cif.state_o), 32'(IDLE));
    chk("c_arm_clr_rem", 32'(cif.remaining), 32'd0);

    // Reset mid-cook
    do_load(13'd8);
    cif.start = 1'b1; step();
    chk("r_rem8", 32'(cif.remaining), 32'd8);
    rst = 1'b1;
    cif.tick_1hz = 1'b1; step();
    rst = 1'b0;
    chk("r_st",   32'(cif.state_o), 32'(IDLE));
    chk("r_rem",  32'(cif.remaining), 32'd0);
    chk("r_mag",  32'(cif.magnetron_on), 32'd0);
    chk("r_lamp", 32'(cif.lamp_on), 32'd0);
    chk("r_beep", 32'(cif.beep), 32'd0);
    chk("r_done", 32'(cif.done), 32'd0);

    // Door opened during DONE ends the beep at once
    do_load(13'd1);
    cif.start = 1'b1; step();
    cif.tick_1hz = 1'b1; step();
    chk("x_done", 32'(cif.state_o), 32'(DONE));
    cif.door_open = 1'b1; step();
    chk("x_idle", 32'(cif.state_o), 32'(IDLE));
    chk("x_beep", 32'(cif.beep), 32'd0);
    cif.door_open = 1'b0;

    // Quick start behaviour (or its absence)
    cif.start = 1'b1; step();
`ifdef MICROWAVE_QUICK_START_EN
    chk("q_idle_st",  32'(cif.state_o), 32'(COOKING));
    chk("q_idle_rem", 32'(cif.remaining), 32'd30);
`else
    chk("q_idle_st",  32'(cif.state_o), 32'(IDLE));
    chk("q_idle_rem", 32'(cif.remaining), 32'd0);
`endif
    cif.stop_clear = 1'b1; step();
    cif.stop_clear = 1'b1; step();
    chk("q_cleared", 32'(cif.state_o), 32'(IDLE));
    do_load(13'd5980);
    cif.start = 1'b1; step();
    chk("q_cook", 32'(cif.state_o), 32'(COOKING));
    cif.start = 1'b1; step();
`ifdef MICROWAVE_QUICK_START_EN
    chk("q_add_sat", 32'(cif.remaining), 32'd5999);
`else
    chk("q_add_ign", 32'(cif.remaining), 32'd5980);
`endif
    chk("q_still_cook", 32'(cif.state_o), 32'(COOKING));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
